// File: rtl/pwm_capture_pkg.sv
// Shared motor-control parameters: default measurement widths/timeouts and
// the capture FSM state encoding. Used by the PWM capture block and the PWM
// generator so both agree on counter width and timeout defaults.
package pwm_capture_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 20;
  localparam int unsigned TIMEOUT_DEF   = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer plus one edge-detect register for an asynchronous
// PWM input.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   pwm_i   : asynchronous PWM input
//   level_o : synchronized level (second synchronizer flop)
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module pwm_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pwm_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;
  assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
//   Clk_i        : system clock
//   Reset_i      : asynchronous active-high reset
//   Pwm_i        : asynchronous PWM input
//   High_cnt_o   : high time of the last complete period (cycles)
//   Period_cnt_o : last complete period (cycles)
//   Valid_o      : one-cycle strobe when the count outputs update
//   Timeout_o    : sticky, no period completed within TIMEOUT_P cycles
//   Level_o      : synchronized input level
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_WIDTH_P = CNT_WIDTH_DEF,
  parameter int unsigned TIMEOUT_P   = TIMEOUT_DEF
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic                   Pwm_i,
  output logic [CNT_WIDTH_P-1:0] High_cnt_o,
  output logic [CNT_WIDTH_P-1:0] Period_cnt_o,
  output logic                   Valid_o,
  output logic                   Timeout_o,
  output logic                   Level_o
);

  localparam logic [CNT_WIDTH_P-1:0] TIMEOUT_C = CNT_WIDTH_P'(TIMEOUT_P);
  localparam logic [CNT_WIDTH_P-1:0] ONE_C     = CNT_WIDTH_P'(1);

  logic rise, fall;

  pwm_sync_edge u_sync (
    .clk_i   (Clk_i),
    .rst_i   (Reset_i),
    .pwm_i   (Pwm_i),
    .level_o (Level_o),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  cap_state_e             state_q, state_d;
  logic [CNT_WIDTH_P-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH_P-1:0] cap_q, cap_d;      // high time of the period in progress
  logic [CNT_WIDTH_P-1:0] high_q, high_d;
  logic [CNT_WIDTH_P-1:0] per_q, per_d;
  logic                   valid_q, valid_d;
  logic                   to_q, to_d;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      high_q  <= '0;
      per_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      high_q  <= high_d;
      per_q   <= per_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end

  // The counter is 1 in the cycle after a rise pulse, so its value in the
  // cycle of the next edge pulse is exactly the distance between pulses.
  // The timeout check takes priority, which keeps the counter bounded by
  // TIMEOUT_P and therefore free of wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    high_d  = high_q;
    per_d   = per_q;
    valid_d = 1'b0;
    to_d    = to_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_C;
        end
      end
      ST_HIGH: begin
        if (cnt_q == TIMEOUT_C) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (fall) begin
            state_d = ST_LOW;
            cap_d   = cnt_q;
          end
        end
      end
      ST_LOW: begin
        if (cnt_q == TIMEOUT_C) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = ONE_C;
          per_d   = cnt_q;
          high_d  = cap_q;
          valid_d = 1'b1;
          to_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign High_cnt_o   = high_q;
  assign Period_cnt_o = per_q;
  assign Valid_o      = valid_q;
  assign Timeout_o    = to_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus randomized
// waveforms checked against a rise-to-rise / rise-to-fall reference model.
module tb_pwm_capture;

  localparam int W  = 20;
  localparam int TO = 5000;

  logic         Clk_i = 1'b0;
  logic         Reset_i = 1'b0;
  logic         Pwm_i = 1'b0;
  logic [W-1:0] High_cnt_o, Period_cnt_o;
  logic         Valid_o, Timeout_o, Level_o;

  pwm_capture #(.CNT_WIDTH_P(W), .TIMEOUT_P(TO)) dut (
    .Clk_i        (Clk_i),
    .Reset_i      (Reset_i),
    .Pwm_i        (Pwm_i),
    .High_cnt_o   (High_cnt_o),
    .Period_cnt_o (Period_cnt_o),
    .Valid_o      (Valid_o),
    .Timeout_o    (Timeout_o),
    .Level_o      (Level_o)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct {
    int   per;
    int   hi;
    int   cyc;
    logic to;
  } vrec_t;

  vrec_t vq[$];
  int    cyc = 0;
  int    tcyc = -1;
  logic  to_prev = 1'b0;
  int    total = 0;
  int    bad = 0;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge Clk_i) begin
    vrec_t r;
    cyc = cyc + 1;
    if (Valid_o) begin
      r.per = int'(Period_cnt_o);
      r.hi  = int'(High_cnt_o);
      r.cyc = cyc;
      r.to  = Timeout_o;
      vq.push_back(r);
    end
    if (Timeout_o && !to_prev) tcyc = cyc;
    to_prev = Timeout_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk_i);
    #1;
  endtask

  task automatic drive_period(input int p, input int h);
    Pwm_i = 1'b1;
    step(h);
    Pwm_i = 1'b0;
    step(p - h);
  endtask

  task automatic do_reset();
    Pwm_i   = 1'b0;
    Reset_i = 1'b1;
    step(3);
    Reset_i = 1'b0;
    step(2);
    vq.delete();
    tcyc = -1;
  endtask

  task automatic test_reset();
    Reset_i = 1'b1;
    #2;
    total++;
    if ({High_cnt_o, Period_cnt_o, Valid_o, Timeout_o, Level_o} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h/%h/%b/%b/%b exp=0", High_cnt_o, Period_cnt_o,
               Valid_o, Timeout_o, Level_o);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    repeat (3) drive_period(1000, 250);
    step(10);
    total++;
    if (vq.size() !== 2) begin
      bad++; $display("FAIL basic_count got=%0d exp=2", vq.size());
    end
    foreach (vq[i]) begin
      total++;
      if (vq[i].per !== 1000 || vq[i].hi !== 250) begin
        bad++; $display("FAIL basic_val%0d got=%0d/%0d exp=1000/250", i, vq[i].per, vq[i].hi);
      end
    end
    if (vq.size() == 2) begin
      total++;
      if (vq[1].cyc - vq[0].cyc !== 1000) begin
        bad++; $display("FAIL basic_spacing got=%0d exp=1000", vq[1].cyc - vq[0].cyc);
      end
    end
  endtask

  task automatic test_duty_step();
    int exp_hi[2] = '{250, 750};
    do_reset();
    drive_period(1000, 250);
    drive_period(1000, 750);
    drive_period(1000, 250);
    step(10);
    total++;
    if (vq.size() !== 2) begin
      bad++; $display("FAIL duty_count got=%0d exp=2", vq.size());
    end
    for (int i = 0; i < 2 && i < vq.size(); i++) begin
      total++;
      if (vq[i].per !== 1000 || vq[i].hi !== exp_hi[i]) begin
        bad++; $display("FAIL duty_val%0d got=%0d/%0d exp=1000/%0d", i, vq[i].per, vq[i].hi,
                        exp_hi[i]);
      end
    end
  endtask

  task automatic test_min_wave();
    do_reset();
    repeat (8) drive_period(2, 1);
    step(10);
    total++;
    if (vq.size() !== 7) begin
      bad++; $display("FAIL min_count got=%0d exp=7", vq.size());
    end
    foreach (vq[i]) begin
      total++;
      if (vq[i].per !== 2 || vq[i].hi !== 1 || (i > 0 && vq[i].cyc - vq[i-1].cyc !== 2)) begin
        bad++; $display("FAIL min_val%0d got=%0d/%0d exp=2/1 every 2 cycles", i, vq[i].per,
                        vq[i].hi);
      end
    end
  endtask

  // Reference: every rise after the first closes a period whose length and
  // high time are the previously driven pair.
  task automatic test_random();
    int ps[$], hs[$];
    for (int round = 0; round < 3; round++) begin
      do_reset();
      ps.delete(); hs.delete();
      for (int k = 0; k < 6; k++) begin
        int p, h;
        p = int'($urandom_range(300, 2));
        h = int'($urandom_range(p - 1, 1));
        ps.push_back(p); hs.push_back(h);
        drive_period(p, h);
      end
      step(10);
      total++;
      if (vq.size() !== ps.size() - 1) begin
        bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", round, vq.size(), ps.size() - 1);
      end
      for (int i = 0; i < vq.size() && i < ps.size() - 1; i++) begin
        total++;
        if (vq[i].per !== ps[i] || vq[i].hi !== hs[i]) begin
          bad++; $display("FAIL rand%0d_val%0d got=%0d/%0d exp=%0d/%0d", round, i, vq[i].per,
                          vq[i].hi, ps[i], hs[i]);
        end
      end
    end
  endtask

  task automatic test_timeout_low();
    do_reset();
    repeat (2) drive_period(1000, 250);
    step(TO + 100);
    total++;
    if (vq.size() !== 1) begin
      bad++; $display("FAIL tol_count got=%0d exp=1", vq.size());
    end
    total++;
    if (Timeout_o !== 1'b1 || Level_o !== 1'b0) begin
      bad++; $display("FAIL tol_flags got=to%b/lvl%b exp=to1/lvl0", Timeout_o, Level_o);
    end
    total++;
    if (Period_cnt_o !== W'(1000) || High_cnt_o !== W'(250)) begin
      bad++; $display("FAIL tol_hold got=%0d/%0d exp=1000/250", Period_cnt_o, High_cnt_o);
    end
    if (vq.size() >= 1) begin
      total++;
      if (tcyc - vq[0].cyc !== TO) begin
        bad++; $display("FAIL tol_delay got=%0d exp=%0d", tcyc - vq[0].cyc, TO);
      end
    end
  endtask

  task automatic test_timeout_high();
    do_reset();
    repeat (2) drive_period(1000, 250);
    Pwm_i = 1'b1;
    step(TO + 100);
    total++;
    if (vq.size() !== 2) begin
      bad++; $display("FAIL toh_count got=%0d exp=2", vq.size());
    end
    total++;
    if (Timeout_o !== 1'b1 || Level_o !== 1'b1) begin
      bad++; $display("FAIL toh_flags got=to%b/lvl%b exp=to1/lvl1", Timeout_o, Level_o);
    end
    total++;
    if (Period_cnt_o !== W'(1000) || High_cnt_o !== W'(250)) begin
      bad++; $display("FAIL toh_hold got=%0d/%0d exp=1000/250", Period_cnt_o, High_cnt_o);
    end
    if (vq.size() >= 2) begin
      total++;
      if (tcyc - vq[1].cyc !== TO) begin
        bad++; $display("FAIL toh_delay got=%0d exp=%0d", tcyc - vq[1].cyc, TO);
      end
    end
  endtask

  // Runs straight after test_timeout_high, with the block timed out.
  task automatic test_resume();
    Pwm_i = 1'b0;
    step(20);
    total++;
    if (Timeout_o !== 1'b1) begin
      bad++; $display("FAIL resume_sticky got=%b exp=1", Timeout_o);
    end
    vq.delete();
    repeat (3) drive_period(400, 100);
    step(10);
    total++;
    if (vq.size() !== 2) begin
      bad++; $display("FAIL resume_count got=%0d exp=2", vq.size());
    end
    if (vq.size() >= 1) begin
      total++;
      if (vq[0].per !== 400 || vq[0].hi !== 100 || vq[0].to !== 1'b0) begin
        bad++; $display("FAIL resume_first got=%0d/%0d/to%b exp=400/100/to0", vq[0].per,
                        vq[0].hi, vq[0].to);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (2) drive_period(1000, 250);
    Pwm_i = 1'b1;
    step(100);
    #2;
    Reset_i = 1'b1;
    #1;
    total++;
    if ({High_cnt_o, Period_cnt_o, Valid_o, Timeout_o, Level_o} !== '0) begin
      bad++;
      $display("FAIL reset_async got=%h/%h/%b/%b/%b exp=0", High_cnt_o, Period_cnt_o,
               Valid_o, Timeout_o, Level_o);
    end
    step(5);
    Pwm_i = 1'b0;
    step(20);
    Reset_i = 1'b0;
    vq.delete();
    step(20);
    drive_period(300, 120);
    total++;
    if (vq.size() !== 0) begin
      bad++; $display("FAIL reset_early got=%0d exp=0", vq.size());
    end
    drive_period(300, 120);
    step(10);
    total++;
    if (vq.size() !== 1) begin
      bad++; $display("FAIL reset_after_count got=%0d exp=1", vq.size());
    end else if (vq[0].per !== 300 || vq[0].hi !== 120) begin
      bad++; $display("FAIL reset_after_val got=%0d/%0d exp=300/120", vq[0].per, vq[0].hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_step();
    test_min_wave();
    test_random();
    test_timeout_low();
    test_timeout_high();
    test_resume();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
